mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single 8-bit memory port of the multicycle MIPS core between the CPU controller (instruction fetch, load, store) and a DMA/program-loader requester.
- Sits between the core datapath (memread/memwrite/address/write data) and the external memory, which may insert wait states.
- Sequences one access at a time with round-robin arbitration.
- Returns a completion strobe so the controller can stall its state machine until data is valid.

Parameters:
- WIDTH, 8, data width of the memory port.
- AW, 8, address width.
- TIMEOUT, 15, maximum wait cycles for mem_ready before an access is aborted. Used only with the optional feature. Must be at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  CPU read request; this is the controller's memread.
- cpu_wr  in  1  CPU write request; this is the controller's memwrite.
- cpu_adr  in  AW  CPU address.
- cpu_wd  in  WIDTH  CPU write data.
- cpu_done  out  1  one-cycle pulse when the CPU access completes.
- dma_req  in  1  DMA request; held until dma_done.
- dma_we  in  1  DMA write (1) or read (0).
- dma_adr  in  AW  DMA address.
- dma_wd  in  WIDTH  DMA write data.
- dma_done  out  1  one-cycle pulse when the DMA access completes.
- rdata  out  WIDTH  read data, valid in the cycle of a done pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wd  out  WIDTH  memory write data.
- mem_rd  in  WIDTH  memory read data.
- mem_ready  in  1  memory access complete.
- err  out  1  sticky timeout flag. Tied to 0 when the optional feature is not compiled in.

Behaviour:
- Reset values:
  - State IDLE, last_grant=DMA (so the CPU wins the first tie).
  - All outputs 0; wait counter 0.
- IDLE:
  - cpu_req = cpu_rd|cpu_wr.
  - Only cpu_req asserted -> CPU_ACC.
  - Only dma_req asserted -> DMA_ACC.
  - Both asserted -> the requester that is not last_grant wins.
- On entering CPU_ACC or DMA_ACC:
  - The winner's address, write data and we are latched into mem_adr, mem_wd and mem_we.
  - CPU we is cpu_wr.
  - mem_en=1 from the next cycle onward.
  - Requester inputs are ignored until completion.
- ACC states:
  - mem_en is held while mem_ready=0.
  - On the first cycle with mem_ready=1, go to DONE. On that edge, rdata<=mem_rd (reads only; writes leave rdata unchanged), mem_en<=0 and mem_we<=0.
- DONE (one cycle):
  - Pulse the granted requester's done.
  - Update last_grant.
  - Return to IDLE.
- Minimum latency: request seen in IDLE -> done pulse 3 cycles later with zero wait states.
- Back-to-back: a requester whose request is still high in IDLE after DONE is re-arbitrated. Round-robin gives the other requester the port if it is pending.
- cpu_rd and cpu_wr both high is illegal. The arbiter treats it as a write.
- A request dropped mid-access does not cancel the access; the access still completes.
- Asynchronous reset mid-access: immediate return to the reset state, mem_en deasserted combinationally via the flops, no done pulse.
- mem_ready in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A 4-bit-minimum counter (width clog2(TIMEOUT+1)) increments each ACC cycle with mem_ready=0.
  - On reaching TIMEOUT: go to DONE, pulse done, rdata<=0, set err=1.
  - err stays set until reset.
- Undefined:
  - No counter; ACC waits indefinitely.
  - err is tied to 0.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state enum: IDLE=2'b00, CPU_ACC=2'b01, DMA_ACC=2'b10, DONE=2'b11.
  - grant encoding: GNT_CPU=1'b0, GNT_DMA=1'b1.
- Sub-module rr_pick2: two request inputs plus last_grant; outputs the one-hot grant. Purely combinational, reused later for the I/O bus.

Test Plan:
- CPU read, address 8'h10, memory returns 8'hA5 with mem_ready on the first ACC cycle -> cpu_done 3 cycles after the request; rdata=8'hA5; dma_done stays 0.
- CPU and DMA request in the same cycle from reset -> CPU granted first; DMA granted in the next IDLE; the second simultaneous pair is granted DMA first.
- DMA write to address 8'h3C with data 8'h77 and 4 wait states -> mem_en high for 5 cycles with mem_adr=8'h3C, mem_we=1, mem_wd=8'h77; dma_done 1 cycle after mem_ready; rdata unchanged.
- Reset asserted low during DMA_ACC -> mem_en=0 immediately, no done pulse, next request served from IDLE with the CPU winning a tie.
- With MEM_ARBITER_TIMEOUT_EN, TIMEOUT=15, mem_ready held 0 -> done pulses after 15 wait cycles, rdata=0, err=1 and stays 1 across later accesses.
- CPU read held high across completion while DMA is pending -> DMA granted next, then the CPU; no starvation over 10 iterations.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory-port arbiter.
// The optional access timeout is enabled by defining MEM_ARBITER_TIMEOUT_EN.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CPU_ACC = 2'b01,
        DMA_ACC = 2'b10,
        DONE    = 2'b11
    } state_t;

    // Grant encoding; also the meaning of last_grant.
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;

    // Wait counter width: enough to hold TIMEOUT, never narrower than 4 bits.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 4) begin
            w = 4;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin picker, purely combinational.
// Outputs a one-hot grant (bit 0 = req0, bit 1 = req1); on a tie the
// requester that did not receive the last grant wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Pick a winner; last_grant uses the GNT_CPU/GNT_DMA code for req0/req1.
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            if (last_grant == GNT_CPU) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU controller and a DMA
// requester, one access at a time, round-robin on ties. An access spends
// one setup cycle with the address/data stable before mem_en rises, then
// holds mem_en until mem_ready; the done pulse and read data appear in the
// following DONE cycle. Define MEM_ARBITER_TIMEOUT_EN to abort accesses
// that wait TIMEOUT cycles for mem_ready (sets the sticky err flag).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [AW-1:0]    cpu_adr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_done,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [AW-1:0]    dma_adr,
    input  logic [WIDTH-1:0] dma_wd,
    output logic             dma_done,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    input  logic             mem_ready,
    output logic             err
);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_grant_r;
    logic             gnt_r;
    logic [1:0]       gnt_s;
    logic             cpu_req_s;
    logic             acc_s;
    logic             fin_s;
    logic             to_s;
    logic             mem_en_r;
    logic             mem_we_r;
    logic [AW-1:0]    mem_adr_r;
    logic [WIDTH-1:0] mem_wd_r;
    logic [WIDTH-1:0] rdata_r;
    logic             cpu_done_r;
    logic             dma_done_r;

    assign cpu_req_s = cpu_rd | cpu_wr;
    assign acc_s     = (state_r == CPU_ACC) || (state_r == DMA_ACC);
    // An access ends on mem_ready or on timeout, only once the strobe is up.
    assign fin_s     = acc_s && mem_en_r && (mem_ready || to_s);

    rr_pick2 u_pick (
        .req0       (cpu_req_s),
        .req1       (dma_req),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] wcnt_r;
    logic             err_r;

    assign to_s = acc_s && mem_en_r && !mem_ready
                  && (wcnt_r == CNT_W'(TIMEOUT - 1));

    // Count strobed wait cycles of the current access; sticky error on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_r <= {CNT_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            if (!acc_s) begin
                wcnt_r <= {CNT_W{1'b0}};
            end else if (mem_en_r && !mem_ready) begin
                wcnt_r <= wcnt_r + CNT_W'(1);
            end else begin
                wcnt_r <= wcnt_r;
            end
            err_r <= err_r | to_s;
        end
    end

    assign err = err_r;
`else
    assign to_s = 1'b0;
    assign err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for completion, one DONE cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_s[0]) begin
                    state_nxt_s = CPU_ACC;
                end else if (gnt_s[1]) begin
                    state_nxt_s = DMA_ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (fin_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: latch the winner, drive the strobe, capture read data, pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_adr_r    <= {AW{1'b0}};
            mem_wd_r     <= {WIDTH{1'b0}};
            rdata_r      <= {WIDTH{1'b0}};
            cpu_done_r   <= 1'b0;
            dma_done_r   <= 1'b0;
            gnt_r        <= GNT_CPU;
            last_grant_r <= GNT_DMA;
        end else begin
            cpu_done_r <= 1'b0;
            dma_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gnt_s[0]) begin
                        mem_adr_r <= cpu_adr;
                        mem_wd_r  <= cpu_wd;
                        mem_we_r  <= cpu_wr;
                        gnt_r     <= GNT_CPU;
                    end else if (gnt_s[1]) begin
                        mem_adr_r <= dma_adr;
                        mem_wd_r  <= dma_wd;
                        mem_we_r  <= dma_we;
                        gnt_r     <= GNT_DMA;
                    end
                end
                CPU_ACC, DMA_ACC: begin
                    if (!mem_en_r) begin
                        mem_en_r <= 1'b1;
                    end else if (fin_s) begin
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        if (to_s) begin
                            rdata_r <= {WIDTH{1'b0}};
                        end else if (!mem_we_r) begin
                            rdata_r <= mem_rd;
                        end
                        if (gnt_r == GNT_CPU) begin
                            cpu_done_r <= 1'b1;
                        end else begin
                            dma_done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    last_grant_r <= gnt_r;
                end
                default: begin
                    mem_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en   = mem_en_r;
    assign mem_we   = mem_we_r;
    assign mem_adr  = mem_adr_r;
    assign mem_wd   = mem_wd_r;
    assign rdata    = rdata_r;
    assign cpu_done = cpu_done_r;
    assign dma_done = dma_done_r;

endmodule
